// File: rtl/shift_seq_pkg.sv
`default_nettype none
// ==================================================================
// Module : shift_seq_pkg -- opcode and FSM state encodings
// Rev    : 1.0  initial release
// ==================================================================
package shift_seq_pkg;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic op_is_ror(input logic [1:0] op);
        return op == OP_ROR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_step_1b.sv
`default_nettype none
// ==================================================================
// Module : shift_step_1b -- combinational single-bit shift/rotate step
// Config : SHIFT_SEQ_ROTATE_EN builds the ROR step
// Rev    : 1.0  initial release
// ==================================================================
module shift_step_1b
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = {1'b0, data[WIDTH-1:1]};
        case (op)
            OP_LSL:  result = {data[WIDTH-2:0], 1'b0};
            OP_LSR:  result = {1'b0, data[WIDTH-1:1]};
            OP_ASR:  result = {data[WIDTH-1], data[WIDTH-1:1]};
`ifdef SHIFT_SEQ_ROTATE_EN
            OP_ROR:  result = {data[0], data[WIDTH-1:1]};
`endif
            default: result = {1'b0, data[WIDTH-1:1]};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/shift_seq_unit.sv
`default_nettype none
// ==================================================================
// Module : shift_seq_unit -- multi-cycle 1-bit-per-clock shifter, valid/ready
// Config : SHIFT_SEQ_ROTATE_EN enables ROR on op 11 (else op 11 acts as LSR)
// Rev    : 1.0  initial release
// ==================================================================
module shift_seq_unit
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam logic [AMT_W-1:0] WIDTH_CNT = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] CNT_ONE   = AMT_W'(1);

    logic [1:0]       state;
    logic [WIDTH-1:0] data_q;
    logic [AMT_W-1:0] count;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] result;

    logic [WIDTH-1:0] step_data;
    logic [AMT_W-1:0] acc_count;
    logic [1:0]       acc_op;
    logic             accept;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign out_data  = result;
    assign accept    = in_valid && in_ready;

    // Linear shifts saturate at WIDTH steps; a rotate only needs amt mod WIDTH.
    always_comb begin
        acc_op    = in_op;
        acc_count = (in_amt > WIDTH_CNT) ? WIDTH_CNT : in_amt;
`ifdef SHIFT_SEQ_ROTATE_EN
        if (op_is_ror(in_op)) begin
            acc_count = in_amt % WIDTH_CNT;
        end
`else
        if (op_is_ror(in_op)) begin
            acc_op = OP_LSR;
        end
`endif
    end

    shift_step_1b #(
        .WIDTH (WIDTH)
    ) u_step (
        .data   (data_q),
        .op     (op_q),
        .result (step_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= (acc_count == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (count == CNT_ONE) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Result is captured on the edge entering DONE so it survives the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            count  <= '0;
            op_q   <= OP_LSL;
            result <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        data_q <= in_data;
                        op_q   <= acc_op;
                        count  <= acc_count;
                        if (acc_count == '0) begin
                            result <= in_data;
                        end
                    end
                end
                ST_SHIFT: begin
                    data_q <= step_data;
                    count  <= count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        result <= step_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_unit.sv
`default_nettype none
// ==================================================================
// Module : tb_shift_seq_unit -- self-checking bench for shift_seq_unit
// Config : honours SHIFT_SEQ_ROTATE_EN in the same way as the design
// Rev    : 1.0  initial release
// ==================================================================
module tb_shift_seq_unit;

    localparam int W = 4;
    localparam int A = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic [A-1:0] in_amt = '0;
    logic [1:0]   in_op = 2'b00;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         busy;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    shift_seq_unit #(.WIDTH(W), .AMT_W(A)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Reference: whole-word shift/rotate by the full amount.
    function automatic logic [W-1:0] model_result(input logic [W-1:0] d, input int amt,
                                                  input logic [1:0] op);
        logic [2*W-1:0] dd;
        logic [W-1:0]   r;
`ifndef SHIFT_SEQ_ROTATE_EN
        if (op == 2'b11) op = 2'b01;
`endif
        case (op)
            2'b00:   r = (amt >= W) ? '0 : (d << amt);
            2'b01:   r = d >> amt;
            2'b10:   r = $signed(d) >>> amt;
            default: begin
                dd = {d, d} >> (amt % W);
                r  = dd[W-1:0];
            end
        endcase
        return r;
    endfunction

    function automatic int model_latency(input int amt, input logic [1:0] op);
`ifdef SHIFT_SEQ_ROTATE_EN
        if (op == 2'b11) return amt % W;
`endif
        return (amt < W) ? amt : W;
    endfunction

    // Issue one request at the current negedge and follow it through to the handshake.
    task automatic run_txn(input logic [W-1:0] d, input logic [A-1:0] a, input logic [1:0] op,
                           input logic [W-1:0] exp_d, input int exp_lat, input int bp,
                           input string tag);
        int cyc;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL %s idle_ready: got %b expected 1", tag, in_ready);
        end
        in_valid  = 1'b1;
        in_data   = d;
        in_amt    = a;
        in_op     = op;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 3 * W) begin
            compared++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL %s busy_shift: busy=%b in_ready=%b expected 1/0", tag, busy, in_ready);
            end
            in_data  = W'($urandom);
            in_amt   = A'($urandom);
            in_op    = 2'($urandom);
            in_valid = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        compared++;
        if (out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL %s timeout: out_valid=%b after %0d cycles", tag, out_valid, cyc);
        end
        compared++;
        if (cyc !== exp_lat) begin
            mismatched++;
            $display("FAIL %s latency: got %0d expected %0d", tag, cyc, exp_lat);
        end
        compared++;
        if (out_data !== exp_d) begin
            mismatched++;
            $display("FAIL %s data: got %b expected %b (in %b amt %0d op %b)", tag, out_data, exp_d, d, a, op);
        end
        compared++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL %s done_flags: in_ready=%b busy=%b expected 0/1", tag, in_ready, busy);
        end
        repeat (bp) begin
            @(negedge clk);
            compared++;
            if (out_valid !== 1'b1 || out_data !== exp_d || in_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL %s stall: out_valid=%b out_data=%b in_ready=%b expected 1/%b/0",
                         tag, out_valid, out_data, in_ready, exp_d);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL %s release: out_valid=%b in_ready=%b busy=%b expected 0/1/0",
                     tag, out_valid, in_ready, busy);
        end
        compared++;
        if (out_data !== exp_d) begin
            mismatched++;
            $display("FAIL %s retain: got %b expected %b", tag, out_data, exp_d);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%b busy=%b expected 1/0/0000/0",
                     in_ready, out_valid, out_data, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_txn(4'b0110, 3'd1, 2'b00, 4'b1100, 1, 0, "lsl1");
        run_txn(4'b1110, 3'd2, 2'b10, 4'b1111, 2, 0, "asr2");
        run_txn(4'b0011, 3'd5, 2'b01, 4'b0000, 4, 0, "lsr_sat");
        run_txn(4'b0101, 3'd7, 2'b00, 4'b0000, 4, 0, "lsl_sat");
        run_txn(4'b1001, 3'd6, 2'b10, 4'b1111, 4, 0, "asr_sat");
        for (int op = 0; op < 4; op++) begin
            run_txn(4'b1111, 3'd0, 2'(op), 4'b1111, 0, 0, "amt0");
        end
    endtask

    task automatic test_rotate();
`ifdef SHIFT_SEQ_ROTATE_EN
        run_txn(4'b0011, 3'd1, 2'b11, 4'b1001, 1, 0, "ror1");
        run_txn(4'b0011, 3'd5, 2'b11, 4'b1001, 1, 0, "ror5");
        run_txn(4'b0110, 3'd4, 2'b11, 4'b0110, 0, 0, "ror4");
`else
        run_txn(4'b0011, 3'd1, 2'b11, 4'b0001, 1, 0, "op3_lsr1");
        run_txn(4'b1100, 3'd6, 2'b11, 4'b0000, 4, 0, "op3_lsr_sat");
`endif
    endtask

    task automatic test_backpressure();
        run_txn(4'b1010, 3'd2, 2'b01, 4'b0010, 2, 5, "backpressure");
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        logic [A-1:0] a;
        logic [1:0]   op;
        for (int i = 0; i < 40; i++) begin
            d  = W'($urandom);
            a  = A'($urandom);
            op = 2'($urandom);
            run_txn(d, a, op, model_result(d, int'(a), op), model_latency(int'(a), op),
                    int'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            run_txn(4'(i * 3 + 1), 3'(i % 2), 2'(i), model_result(4'(i * 3 + 1), i % 2, 2'(i)),
                    model_latency(i % 2, 2'(i)), 0, "b2b");
        end
    endtask

    task automatic test_reset_mid_shift();
        in_valid = 1'b1;
        in_data  = 4'b0110;
        in_amt   = 3'd3;
        in_op    = 2'b00;
        @(negedge clk);
        in_valid = 1'b0;
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_mid busy_before: got %b expected 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid async: out_valid=%b out_data=%b in_ready=%b busy=%b expected 0/0000/1/0",
                     out_valid, out_data, in_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            compared++;
            if (out_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL rst_mid aborted: out_valid=%b expected 0 at cycle %0d", out_valid, i);
            end
        end
        run_txn(4'b1000, 3'd3, 2'b10, 4'b1111, 3, 1, "after_rst");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_rotate();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/shift_seq_unit.md
Name: shift_seq_unit

Overview:
- Multi-cycle sequential shifter: accepts a WIDTH-bit word, a shift amount and an opcode through a valid/ready handshake.
- Applies one single-bit shift per clock until the count is exhausted, then presents the result on a valid/ready output port.
- Sits directly upstream of the combinational left/right shift stage: it supplies variable-amount shifted words to that stage and to downstream datapath logic.

Parameters:
- WIDTH, 4, data word width in bits (minimum 2).
- AMT_W, 3, width of the shift-amount field; must satisfy 2^AMT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_data  input  WIDTH  operand.
- in_amt  input  AMT_W  shift amount.
- in_op  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR (see Optional Feature).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  shifted result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (async assert, sync release): state IDLE; in_ready=1; out_valid=0; out_data=0; busy=0; internal data, count and op registers cleared.
- Reset asserted mid-operation aborts the request with no output.
- FSM states: IDLE, SHIFT, DONE. in_ready = (state==IDLE). No request overlap.
- IDLE:
  - On in_valid & in_ready at edge E0: latch in_data, in_op and effective count.
  - Effective count = min(in_amt, WIDTH) for LSL/LSR/ASR; in_amt mod WIDTH for ROR.
  - Next state is DONE if effective count == 0, otherwise SHIFT.
- SHIFT: every edge performs one 1-bit step on the data register and decrements the count. When the count is 1 at that edge, the next state is DONE.
- 1-bit step per op:
  - LSL: {d[W-2:0],0}.
  - LSR: {0,d[W-1:1]}.
  - ASR: {d[W-1],d[W-1:1]}.
  - ROR: {d[0],d[W-1:1]}.
- Latency: out_valid is high in the cycle following edge E0+effective count. For example, amt 0 gives out_valid right after the accept edge; amt 3 gives it three edges later.
- DONE:
  - out_valid=1 and out_data = data register, both held stable while out_ready=0 (backpressure, unbounded).
  - On out_valid & out_ready, go to IDLE at that edge. out_valid drops; out_data retains its value.
  - The next request is accepted no earlier than the following cycle.
- Saturation results:
  - LSL/LSR with amt ≥ WIDTH give all zeros, produced in exactly WIDTH shift cycles.
  - ASR with amt ≥ WIDTH gives all bits equal to the original MSB.
- Inputs are ignored outside IDLE. in_data, in_amt and in_op changing while not accepted have no effect.

Optional Feature:
- Macro SHIFT_SEQ_ROTATE_EN.
- Defined: op 11 performs ROR as specified above.
- Undefined: op 11 is decoded as LSR, the ROR logic and the modulo count path are not built, and the results equal the LSR case.

Decomposition:
- Package shift_seq_pkg holds:
  - op encodings OP_LSL=2'b00, OP_LSR=2'b01, OP_ASR=2'b10, OP_ROR=2'b11;
  - state encodings ST_IDLE, ST_SHIFT, ST_DONE (2-bit).
- One sub-module: shift_step_1b. It is combinational, takes WIDTH-bit data and op, and returns the single-bit-shifted word. It is instantiated once in the SHIFT datapath.

Test Plan:
- LSL 1: in_data=0110, amt=1, op=LSL, out_ready=1 → out_valid one edge after accept, out_data=1100, then back to IDLE.
- ASR 2: in_data=1110, amt=2, op=ASR → out_data=1111 two edges after accept; busy high throughout.
- LSR saturation: in_data=0011, amt=5, op=LSR → out_data=0000 after exactly 4 shift edges.
- Amount zero: in_data=1111, amt=0, any op → out_data=1111 in the cycle after accept.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid and out_data stable and in_ready=0. Pulse out_ready → one transfer, in_ready=1 the next cycle.
- Rotate and reset: with SHIFT_SEQ_ROTATE_EN, 0011 ROR 1 → 1001 and 0011 ROR 5 → 1001. Without the macro, 0011 op 11 amt 1 → 0001. Then assert rst_n=0 mid-SHIFT → out_valid=0, out_data=0, in_ready=1 immediately.
